// File: rtl/manchester_decoder.sv
// manchester_decoder: oversampling IEEE 802.3 Manchester receiver.
// Synchronizes the line, qualifies idle, locks on a start bit, re-times on
// every mid-bit transition and delivers one byte per frame.
// Optional feature: define MANCH_PARITY_EN to receive a trailing even-parity bit.
module manchester_decoder #(
    parameter int HALF_PERIOD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_in,
    input  logic       enable,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW     = $clog2(3 * HALF_PERIOD);
    localparam int LO     = (3 * HALF_PERIOD) / 2;
    localparam int HI     = (5 * HALF_PERIOD) / 2;
    localparam int IDLE_N = 2 * HALF_PERIOD;
    localparam int IW     = $clog2(IDLE_N + 1);
`ifdef MANCH_PARITY_EN
    localparam int NBITS  = 9;
`else
    localparam int NBITS  = 8;
`endif
    // Shift register holds all bits but the one arriving on the final edge.
    localparam int SW     = NBITS - 1;

    localparam logic [CW-1:0] CNT_LO    = CW'(LO);
    localparam logic [CW-1:0] CNT_HI    = CW'(HI);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_N - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(NBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state;
    logic            s1, s2, s3;
    logic            edge_det;
    logic            rise_det;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idle_cnt;
    logic [3:0]      bit_idx;
    logic [SW-1:0]   shreg;

    assign edge_det = s2 ^ s3;
    assign rise_det = s2 & ~s3;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= line_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Receive FSM: idle qualification, start lock, mid-bit re-timing, output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idle_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!enable) begin
                state    <= S_IDLE;
                idle_cnt <= '0;
                cnt      <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (s2) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_LAST) begin
                            idle_cnt <= '0;
                            state    <= S_ARMED;
                        end else begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                    end
                    S_ARMED: begin
                        if (rise_det) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            busy    <= 1'b1;
                            state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (cnt > CNT_HI) begin
                            frame_err <= 1'b1;
                            state     <= S_ERR;
                        end else if (edge_det && (cnt >= CNT_LO)) begin
                            cnt     <= '0;
                            bit_idx <= bit_idx + 4'd1;
                            shreg   <= {shreg[SW-2:0], s2};
                            // The final bit is consumed straight from s2 so the
                            // strobe leaves on the same edge that sees the transition.
                            if (bit_idx == LAST_BIT) begin
                                state <= S_DONE;
`ifdef MANCH_PARITY_EN
                                if ((^{shreg, s2}) == 1'b0) begin
                                    data_out   <= shreg;
                                    data_valid <= 1'b1;
                                end else begin
                                    frame_err  <= 1'b1;
                                end
`else
                                data_out   <= {shreg, s2};
                                data_valid <= 1'b1;
`endif
                            end
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_DONE, S_ERR: begin
                        busy     <= 1'b0;
                        idle_cnt <= '0;
                        state    <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_manchester_decoder.sv
// tb_manchester_decoder: directed self-checking bench for manchester_decoder
// (HALF_PERIOD = 8). Parity frames are exercised when MANCH_PARITY_EN is defined.
module tb_manchester_decoder;

    logic       clk;
    logic       rst_n;
    logic       line_in;
    logic       enable;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int         n_cmp;
    int         n_bad;
    int         dv_cnt;
    int         fe_cnt;
    int         both_cnt;
    int         busy_low;
    bit         in_frame;
    logic       busy_at_drop;
    time        mid_time;
    time        dv_time;
    time        fe_time;
    logic [7:0] dv_hist [0:15];

    manchester_decoder #(.HALF_PERIOD(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_in    (line_in),
        .enable     (enable),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Pulse and busy monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (data_valid) begin
            dv_hist[dv_cnt[3:0]] = data_out;
            dv_cnt  = dv_cnt + 1;
            dv_time = $time;
        end
        if (frame_err) begin
            fe_cnt  = fe_cnt + 1;
            fe_time = $time;
        end
        if (data_valid && frame_err) both_cnt = both_cnt + 1;
        if (in_frame && !busy) busy_low = busy_low + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_half(input logic lvl, input int n);
        line_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int h1, input int h2);
        send_half(~b, h1);
        send_half(b, h2);
    endtask

    // Start bit, then bits[nb-1:0] MSB first; records the time of the final mid transition.
    task automatic send_frame(input logic [8:0] bits, input int nb, input int ha, input int hb,
                              input bit drop_en);
        send_bit(1'b1, ha, hb);
        in_frame = 1;
        for (int i = nb - 1; i >= 1; i--) send_bit(bits[i], ha, hb);
        send_half(~bits[0], ha);
        in_frame = 0;
        line_in  = bits[0];
        mid_time = $time;
        if (drop_en) begin
            repeat (2) @(negedge clk);
            enable = 1'b0;
            @(negedge clk);
            busy_at_drop = busy;
            repeat (hb - 3) @(negedge clk);
            enable = 1'b1;
        end else begin
            repeat (hb) @(negedge clk);
        end
        line_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int ha, input int hb, input bit drop_en);
`ifdef MANCH_PARITY_EN
        send_frame({d, ^d}, 9, ha, hb, drop_en);
`else
        send_frame({1'b0, d}, 8, ha, hb, drop_en);
`endif
    endtask

    initial begin
        clk = 0; rst_n = 0; line_in = 0; enable = 1;
        n_cmp = 0; n_bad = 0; dv_cnt = 0; fe_cnt = 0; both_cnt = 0; busy_low = 0;
        in_frame = 0; busy_at_drop = 1'bx;
        mid_time = 0; dv_time = 0; fe_time = 0;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst data_out", 32'(data_out), 32'h00);
        check("rst data_valid", 32'(data_valid), 32'h0);
        check("rst frame_err", 32'(frame_err), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        rst_n = 1;
        repeat (32) @(negedge clk);

        // 0xA5 after 32 idle clocks; strobe 3 clocks after the last mid transition
        send_byte(8'hA5, 8, 8, 0);
        repeat (40) @(negedge clk);
        check("a5 dv count", 32'(dv_cnt), 32'd1);
        check("a5 data", 32'(data_out), 32'hA5);
        check("a5 fe count", 32'(fe_cnt), 32'd0);
        check("a5 latency", 32'(dv_time - mid_time), 32'd30);
        check("a5 busy gaps", 32'(busy_low), 32'd0);
        check("a5 busy after", 32'(busy), 32'h0);

        // 0x00 then 0xFF with a 16-clock gap; trailing fall after 0xFF must not start a frame
        send_byte(8'h00, 8, 8, 0);
        repeat (16) @(negedge clk);
        send_byte(8'hFF, 8, 8, 0);
        repeat (60) @(negedge clk);
        check("b2b dv count", 32'(dv_cnt), 32'd3);
        check("b2b first", 32'(dv_hist[1]), 32'h00);
        check("b2b second", 32'(dv_hist[2]), 32'hFF);
        check("b2b fe count", 32'(fe_cnt), 32'd0);
        check("b2b busy gaps", 32'(busy_low), 32'd0);

        // 0x5A with the line frozen low after the third data bit's mid edge: timeout abort
        send_bit(1'b1, 8, 8);
        send_bit(1'b0, 8, 8);
        send_bit(1'b1, 8, 8);
        send_half(1'b1, 8);
        line_in  = 1'b0;
        mid_time = $time;
        repeat (50) @(negedge clk);
        check("abort fe count", 32'(fe_cnt), 32'd1);
        check("abort fe timing", 32'(fe_time - mid_time), 32'd250);
        check("abort data kept", 32'(data_out), 32'hFF);
        check("abort dv count", 32'(dv_cnt), 32'd3);
        check("abort busy", 32'(busy), 32'h0);

        // 0x3C with alternating 7/9 clock half periods
        send_byte(8'h3C, 7, 9, 0);
        repeat (40) @(negedge clk);
        check("drift dv count", 32'(dv_cnt), 32'd4);
        check("drift data", 32'(data_out), 32'h3C);
        check("drift fe count", 32'(fe_cnt), 32'd1);

        // Reset during data bit 4 of 0x81
        send_bit(1'b1, 8, 8);
        send_bit(1'b1, 8, 8);
        send_bit(1'b0, 8, 8);
        send_bit(1'b0, 8, 8);
        send_bit(1'b0, 8, 8);
        send_half(1'b1, 4);
        check("mid busy", 32'(busy), 32'h1);
        rst_n = 0;
        #1;
        check("mrst data_out", 32'(data_out), 32'h00);
        check("mrst data_valid", 32'(data_valid), 32'h0);
        check("mrst frame_err", 32'(frame_err), 32'h0);
        check("mrst busy", 32'(busy), 32'h0);
        line_in = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1;
        repeat (40) @(negedge clk);
        check("mrst no dv", 32'(dv_cnt), 32'd4);
        check("mrst no fe", 32'(fe_cnt), 32'd1);
        send_byte(8'h81, 8, 8, 0);
        repeat (40) @(negedge clk);
        check("post rst dv count", 32'(dv_cnt), 32'd5);
        check("post rst data", 32'(data_out), 32'h81);

        // enable dropped in the cycle that sees the final mid transition
        send_byte(8'h12, 8, 8, 1);
        repeat (40) @(negedge clk);
        check("dis busy", 32'(busy_at_drop), 32'h0);
        check("dis no dv", 32'(dv_cnt), 32'd5);
        check("dis no fe", 32'(fe_cnt), 32'd1);
        check("dis data kept", 32'(data_out), 32'h81);
        send_byte(8'h6E, 8, 8, 0);
        repeat (40) @(negedge clk);
        check("reen dv count", 32'(dv_cnt), 32'd6);
        check("reen data", 32'(data_out), 32'h6E);

`ifdef MANCH_PARITY_EN
        // Even parity: 0x0F with parity 0 accepted, with parity 1 rejected
        send_frame({8'h0F, 1'b0}, 9, 8, 8, 0);
        repeat (40) @(negedge clk);
        check("par ok dv count", 32'(dv_cnt), 32'd7);
        check("par ok data", 32'(data_out), 32'h0F);
        send_frame({8'h0F, 1'b1}, 9, 8, 8, 0);
        repeat (40) @(negedge clk);
        check("par bad fe count", 32'(fe_cnt), 32'd2);
        check("par bad dv count", 32'(dv_cnt), 32'd7);
        check("par bad data", 32'(data_out), 32'h0F);
`endif

        check("dv and fe overlap", 32'(both_cnt), 32'd0);
        check("busy gaps total", 32'(busy_low), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
